// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one WIDTH-bit adder among NREQ requesters.
// Results are held in a single-entry output slot drained over a valid/ready channel.
module adder_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_cin,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_cout,
    output logic [IDW-1:0]          rsp_id,
    output logic [31:0]             ops_count
);

    function automatic logic [WIDTH:0] add_cin(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             c);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    endfunction

    logic [IDW-1:0]   rr_ptr;
    logic             vld_p1;
    logic [WIDTH-1:0] sum_p1;
    logic             cout_p1;
    logic [IDW-1:0]   id_p1;
    logic [31:0]      ops_count_r;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic             can_accept;
    logic             grant;
    logic             rsp_xfer;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_cin;
    logic [WIDTH:0]   add_res;
    logic [IDW-1:0]   next_ptr;
    int               scan_idx;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NREQ;
            if (!gnt_found && req_valid[scan_idx[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx[IDW-1:0];
            end
        end
    end

    assign rsp_xfer   = vld_p1 & rsp_ready;
    assign can_accept = ~vld_p1 | rsp_ready;
    assign grant      = gnt_found & can_accept;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[gnt_idx] = 1'b1;
    end

    assign sel_a    = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    assign sel_b    = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
    assign sel_cin  = req_cin[gnt_idx];
    assign add_res  = add_cin(sel_a, sel_b, sel_cin);
    assign next_ptr = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    // Stage p1: output slot, loads on grant and drains on response transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            sum_p1      <= '0;
            cout_p1     <= 1'b0;
            id_p1       <= '0;
            rr_ptr      <= '0;
            ops_count_r <= '0;
        end else begin
            if (grant) begin
                vld_p1  <= 1'b1;
                sum_p1  <= add_res[WIDTH-1:0];
                cout_p1 <= add_res[WIDTH];
                id_p1   <= gnt_idx;
                rr_ptr  <= next_ptr;
            end else if (rsp_xfer) begin
                vld_p1  <= 1'b0;
            end
            if (rsp_xfer) ops_count_r <= ops_count_r + 32'd1;
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_sum   = sum_p1;
    assign rsp_cout  = cout_p1;
    assign rsp_id    = id_p1;
    assign ops_count = ops_count_r;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: table-driven single requests plus
// round-robin, back-pressure, async reset and counter-wrap sequences.
module tb_adder_share_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int IDW  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*W-1:0]     req_a;
    logic [NREQ*W-1:0]     req_b;
    logic [NREQ-1:0]       req_cin;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [W-1:0]          rsp_sum;
    logic                  rsp_cout;
    logic [IDW-1:0]        rsp_id;
    logic [31:0]           ops_count;

    int n_checks = 0;
    int n_fail   = 0;

    adder_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
        .ops_count(ops_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic c);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_cin[id]      = c;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_sum",   64'(rsp_sum),   64'd0);
        check("reset rsp_cout",  64'(rsp_cout),  64'd0);
        check("reset rsp_id",    64'(rsp_id),    64'd0);
        check("reset ops_count", 64'(ops_count), 64'd0);
        check("reset req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_sum;
        logic [32:0] wide;

        vt[0] = '{0, 32'd5,          32'd10,         1'b0, 32'd15,         1'b0};
        vt[1] = '{2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF,  1'b1};
        vt[2] = '{1, 32'd15,         32'd20,         1'b1, 32'd36,         1'b0};
        vt[3] = '{3, 32'h8000_0000,  32'h8000_0000,  1'b0, 32'h0000_0000,  1'b1};
        vt[4] = '{1, 32'd0,          32'd0,          1'b1, 32'd1,          1'b0};
        vt[5] = '{3, 32'h7FFF_FFFF,  32'd0,          1'b1, 32'h8000_0000,  1'b0};
        vt[6] = '{0, 32'h1234_5678,  32'h9ABC_DEF0,  1'b0, 32'hACF1_3568,  1'b0};
        vt[7] = '{2, 32'hFFFF_FFFF,  32'd0,          1'b1, 32'h0000_0000,  1'b1};

        do_reset();

        // Single requests from the table, one result drained per vector.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) check("ops after first drain", 64'(ops_count), 64'd1);
            req_a = '0; req_b = '0; req_cin = '0;
            set_req(vt[i].id, vt[i].a, vt[i].b, vt[i].cin);
            req_valid = 4'(1 << vt[i].id);
            @(negedge clk);
            check($sformatf("vec%0d req_ready", i), 64'(req_ready), 64'(1 << vt[i].id));
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            check($sformatf("vec%0d rsp_valid", i), 64'(rsp_valid), 64'd1);
            check($sformatf("vec%0d rsp_sum", i),   64'(rsp_sum),   64'(vt[i].sum));
            check($sformatf("vec%0d rsp_cout", i),  64'(rsp_cout),  64'(vt[i].cout));
            check($sformatf("vec%0d rsp_id", i),    64'(rsp_id),    64'(vt[i].id));
        end
        @(posedge clk); #1;
        check("ops after table", 64'(ops_count), 64'd8);
        check("slot empty after table", 64'(rsp_valid), 64'd0);

        // All requesters valid: strict rotation, one result per cycle.
        do_reset();
        @(posedge clk); #1;
        for (int r = 0; r < NREQ; r++) set_req(r, 32'h100 * (r + 1), 32'(r), r[0]);
        req_valid = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("rr%0d req_ready", k), 64'(req_ready), 64'(1 << (k % NREQ)));
            if (k > 0) begin
                wide = 33'(32'h100 * (((k - 1) % NREQ) + 1)) + 33'((k - 1) % NREQ) + 33'((k - 1) % 2);
                check($sformatf("rr%0d rsp_valid", k), 64'(rsp_valid), 64'd1);
                check($sformatf("rr%0d rsp_id", k),    64'(rsp_id),    64'((k - 1) % NREQ));
                check($sformatf("rr%0d rsp_sum", k),   64'(rsp_sum),   64'(wide[31:0]));
            end
            @(posedge clk);
        end
        #1;
        req_valid = '0;
        @(posedge clk); #1;
        check("rr ops_count", 64'(ops_count), 64'd9);

        // Back-pressure: held result, no grants, pointer preserved across the stall.
        req_a = '0; req_b = '0; req_cin = '0;
        set_req(1, 32'd15, 32'd20, 1'b1);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("hold accept req_ready", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        set_req(0, 32'd7, 32'd0, 1'b0);
        set_req(3, 32'd100, 32'd200, 1'b0);
        req_valid = 4'b1001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d rsp_valid", c), 64'(rsp_valid), 64'd1);
            check($sformatf("hold%0d rsp_sum", c),   64'(rsp_sum),   64'd36);
            check($sformatf("hold%0d rsp_id", c),    64'(rsp_id),    64'd1);
            check($sformatf("hold%0d req_ready", c), 64'(req_ready), 64'd0);
            @(posedge clk);
        end
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("release same-cycle grant", 64'(req_ready), 64'b1000);
        @(posedge clk); #1;
        req_valid = 4'b0001;
        @(negedge clk);
        check("after release rsp_id",  64'(rsp_id),  64'd3);
        check("after release rsp_sum", 64'(rsp_sum), 64'd300);
        check("wrap to req0 ready",    64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("req0 rsp_id",  64'(rsp_id),  64'd0);
        check("req0 rsp_sum", 64'(rsp_sum), 64'd7);
        @(posedge clk); #1;

        // Async reset while FULL, with rr_ptr advanced past 0.
        set_req(2, 32'd1, 32'd2, 1'b0);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("pre-reset full", 64'(rsp_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("async reset ops_count", 64'(ops_count), 64'd0);
        req_valid = 4'b1100;
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset grant from 0", 64'(req_ready), 64'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;

        // Counter wrap from all-ones.
        @(negedge clk);
        force dut.ops_count_r = 32'hFFFF_FFFF;
        #1 release dut.ops_count_r;
        #1 check("ops preload", 64'(ops_count), 64'hFFFF_FFFF);
        @(posedge clk); #1;
        set_req(1, 32'd9, 32'd9, 1'b0);
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = '0;
        exp_sum = 32'd18;
        @(negedge clk);
        check("wrap rsp_sum", 64'(rsp_sum), 64'(exp_sum));
        @(posedge clk); #1;
        check("ops wrap", 64'(ops_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
